vga_pattern_engine: RTL

//  Parametrised VGA timing and test-pattern engine. Generates sync, data-enable
//  and pixel coordinates for any timing set, plus one of four runtime-selectable

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing_core.sv | 97 +++++++++
 rtl/vga_pattern_engine.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing / test-pattern engine.
package vga_pkg;

   typedef enum logic [1:0] {PAT_BARS, PAT_CHECK, PAT_GRAD, PAT_PSYCH} pat_e;

   // 640x480@60 (25.175 MHz pixel clock)
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   // {r,g,b} on/off for colour bar b, left to right
   function automatic logic [2:0] bar_rgb(input logic [2:0] b);
      case (b)
         3'd0: bar_rgb = 3'b111;   // white
         3'd1: bar_rgb = 3'b110;   // yellow
         3'd2: bar_rgb = 3'b011;   // cyan
         3'd3: bar_rgb = 3'b010;   // green
         3'd4: bar_rgb = 3'b101;   // magenta
         3'd5: bar_rgb = 3'b100;   // red
         3'd6: bar_rgb = 3'b001;   // blue
         3'd7: bar_rgb = 3'b000;   // black
      endcase
   endfunction

endpackage

// File: rtl/vga_timing_core.sv
// VGA timing core: h/v counters, sync and data-enable, active-area coordinates.
// Pin outputs are registered one cycle behind the counter state.
module vga_timing_core #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_enable,
   output logic [9:0] o_x,
   output logic [9:0] o_y,
   output logic       o_de_c,
   output logic       o_sof,
   output logic       o_frame_wrap,
   output logic       o_hs,
   output logic       o_vs,
   output logic       o_de,
   output logic [9:0] o_px,
   output logic [9:0] o_py,
   output logic       o_frameStart
);
   localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // +1 so the exclusive sync end still fits when a total is a power of two
   localparam int   HW      = $clog2(H_TOTAL + 1);
   localparam int   VW      = $clog2(V_TOTAL + 1);
   localparam int   HS_BEG  = H_ACTIVE + H_FP;
   localparam int   VS_BEG  = V_ACTIVE + V_FP;
   localparam logic HS_ON   = (HS_POL != 0);
   localparam logic VS_ON   = (VS_POL != 0);

   logic [HW-1:0] r_h;
   logic [VW-1:0] r_v;
   logic          w_h_last;
   logic          w_v_last;
   logic          w_hs;
   logic          w_vs;

   assign w_h_last     = (r_h == HW'(H_TOTAL - 1));
   assign w_v_last     = (r_v == VW'(V_TOTAL - 1));
   assign w_hs         = (r_h >= HW'(HS_BEG)) && (r_h < HW'(HS_BEG + H_SYNC));
   assign w_vs         = (r_v >= VW'(VS_BEG)) && (r_v < VW'(VS_BEG + V_SYNC));
   assign o_de_c       = (r_h < HW'(H_ACTIVE)) && (r_v < VW'(V_ACTIVE));
   assign o_x          = 10'(r_h);
   assign o_y          = 10'(r_v);
   assign o_sof        = (r_h == '0) && (r_v == '0);
   assign o_frame_wrap = w_h_last && w_v_last;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_h <= '0;
         r_v <= '0;
      end else if (!i_enable) begin
         r_h <= '0;
         r_v <= '0;
      end else if (w_h_last) begin
         r_h <= '0;
         r_v <= w_v_last ? '0 : r_v + 1'b1;
      end else begin
         r_h <= r_h + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_hs         <= ~HS_ON;
         o_vs         <= ~VS_ON;
         o_de         <= 1'b0;
         o_px         <= '0;
         o_py         <= '0;
         o_frameStart <= 1'b0;
      end else if (!i_enable) begin
         o_hs         <= ~HS_ON;
         o_vs         <= ~VS_ON;
         o_de         <= 1'b0;
         o_px         <= '0;
         o_py         <= '0;
         o_frameStart <= 1'b0;
      end else begin
         o_hs         <= w_hs ? HS_ON : ~HS_ON;
         o_vs         <= w_vs ? VS_ON : ~VS_ON;
         o_de         <= o_de_c;
         o_px         <= o_de_c ? o_x : '0;
         o_py         <= o_de_c ? o_y : '0;
         o_frameStart <= o_sof;
      end
   end

endmodule

// File: rtl/vga_pattern_engine.sv
// VGA test-pattern engine: timing core plus frame-latched pattern select,
// frame counter and a registered colour stage aligned with sync/de.
module vga_pattern_engine
   import vga_pkg::*;
#(
   parameter int H_ACTIVE   = VGA_H_ACTIVE,
   parameter int H_FP       = VGA_H_FP,
   parameter int H_SYNC     = VGA_H_SYNC,
   parameter int H_BP       = VGA_H_BP,
   parameter int V_ACTIVE   = VGA_V_ACTIVE,
   parameter int V_FP       = VGA_V_FP,
   parameter int V_SYNC     = VGA_V_SYNC,
   parameter int V_BP       = VGA_V_BP,
   parameter int HS_POL     = 0,
   parameter int VS_POL     = 0,
   parameter int CW         = 3,
   parameter int CHECK_LOG2 = 5
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_enable,
   input  logic [1:0]    i_mode,
   output logic          o_hs,
   output logic          o_vs,
   output logic          o_de,
   output logic [9:0]    o_px,
   output logic [9:0]    o_py,
   output logic [CW-1:0] o_red,
   output logic [CW-1:0] o_green,
   output logic [CW-1:0] o_blue,
   output logic          o_frameStart
);
   localparam int            BAR_W = H_ACTIVE / 8;
   localparam logic [CW-1:0] MAX   = '1;

   logic [9:0]    w_x;
   logic [9:0]    w_y;
   logic          w_de;
   logic          w_sof;
   logic          w_fwrap;
   pat_e          r_mode;
   pat_e          w_mode;
   logic [7:0]    r_frame;
   logic [9:0]    w_bar_idx;
   logic [2:0]    w_bar;
   logic [2:0]    w_bar_rgb;
   logic          w_chk;
   logic [9:0]    w_s;
   logic [15:0]   w_xy;
   logic [CW-1:0] w_r;
   logic [CW-1:0] w_g;
   logic [CW-1:0] w_b;
   logic          w_unused;

   vga_timing_core #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) u_timing (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_enable    (i_enable),
      .o_x         (w_x),
      .o_y         (w_y),
      .o_de_c      (w_de),
      .o_sof       (w_sof),
      .o_frame_wrap(w_fwrap),
      .o_hs        (o_hs),
      .o_vs        (o_vs),
      .o_de        (o_de),
      .o_px        (o_px),
      .o_py        (o_py),
      .o_frameStart(o_frameStart)
   );

   // Pixel (0,0) already uses the newly sampled mode, so a frame never mixes two
   assign w_mode = w_sof ? pat_e'(i_mode) : r_mode;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_mode  <= PAT_BARS;
         r_frame <= '0;
      end else begin
         if (w_sof)
            r_mode <= pat_e'(i_mode);
         if (i_enable && w_fwrap)
            r_frame <= r_frame + 8'd1;
      end
   end

   // Bars past the eighth (H_ACTIVE not a multiple of 8) stay on the last bar
   assign w_bar_idx = w_x / 10'(BAR_W);
   assign w_bar     = (w_bar_idx > 10'd7) ? 3'd7 : w_bar_idx[2:0];
   assign w_bar_rgb = bar_rgb(w_bar);
   assign w_chk     = w_x[CHECK_LOG2] ^ w_y[CHECK_LOG2];
   assign w_s       = w_x + w_y + {2'b00, r_frame};
   assign w_xy      = {6'b0, w_x ^ w_y};
   assign w_unused  = ^{w_s, w_xy, w_bar_idx};

   always_comb begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
      case (w_mode)
         PAT_BARS: begin
            w_r = w_bar_rgb[2] ? MAX : '0;
            w_g = w_bar_rgb[1] ? MAX : '0;
            w_b = w_bar_rgb[0] ? MAX : '0;
         end
         PAT_CHECK: begin
            w_r = w_chk ? MAX : '0;
            w_g = w_chk ? MAX : '0;
            w_b = w_chk ? MAX : '0;
         end
         PAT_GRAD: begin
            w_r = w_x[9 -: CW];
            w_g = w_y[8 -: CW];
            w_b = w_x[9 -: CW] ^ w_y[8 -: CW];
         end
         PAT_PSYCH: begin
            w_r = w_s[CW-1:0];
            w_g = w_s[CW+1 -: CW];
            w_b = w_xy[CW+2 -: CW];
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_red   <= '0;
         o_green <= '0;
         o_blue  <= '0;
      end else if (i_enable && w_de) begin
         o_red   <= w_r;
         o_green <= w_g;
         o_blue  <= w_b;
      end else begin
         o_red   <= '0;
         o_green <= '0;
         o_blue  <= '0;
      end
   end

endmodule
